// File: rtl/imm_extend_pipe.sv
// Registered immediate generator with a two-entry skid buffer (valid/ready in and out).
// Optional macro IMM_ERR_EN adds the imm_err output flagging the reserved format 3'b111.
module imm_extend_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [24:0]      instr,
  input  logic [2:0]       ImmSrc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  ImmExt,
  output logic [TAG_W-1:0] out_tag
`ifdef IMM_ERR_EN
  ,
  output logic             imm_err
`endif
);

`ifdef IMM_ERR_EN
  localparam int PW = XLEN + TAG_W + 1;
`else
  localparam int PW = XLEN + TAG_W;
`endif

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  occ_e          state_q, state_d;
  logic [PW-1:0] main_q, main_d;
  logic [PW-1:0] skid_q, skid_d;
  logic [PW-1:0] in_item_s;
  logic          push_s;
  logic          pop_s;

  // instr[k] lives at ins[k-7]; signed formats are assembled at 32 bits, then widened.
  function automatic logic [XLEN-1:0] decode_imm(input logic [24:0] ins, input logic [2:0] sel);
    logic [31:0]     w;
    logic            sx;
    logic [XLEN-1:0] imm;
    w   = 32'd0;
    sx  = 1'b1;
    imm = {XLEN{1'b0}};
    case (sel)
      3'b000: w = {{20{ins[24]}}, ins[24:13]};
      3'b001: w = {{20{ins[24]}}, ins[24:18], ins[4:0]};
      3'b010: w = {{19{ins[24]}}, ins[24], ins[0], ins[23:18], ins[4:1], 1'b0};
      3'b011: w = {{11{ins[24]}}, ins[24], ins[12:5], ins[13], ins[23:14], 1'b0};
      3'b100: w = {ins[24:5], 12'h000};
      3'b101: begin
        w  = {27'd0, ins[12:8]};
        sx = 1'b0;
      end
      3'b110: begin
        w  = (XLEN == 64) ? {26'd0, ins[18:13]} : {27'd0, ins[17:13]};
        sx = 1'b0;
      end
      default: w = {ins[24:5], 12'h000};
    endcase
    if (sx) begin
      imm = XLEN'($signed(w));
    end else begin
      imm = XLEN'(w);
    end
    return imm;
  endfunction

`ifdef IMM_ERR_EN
  assign in_item_s = {decode_imm(instr, ImmSrc), in_tag, (ImmSrc == 3'b111)};
  assign {ImmExt, out_tag, imm_err} = main_q;
`else
  assign in_item_s = {decode_imm(instr, ImmSrc), in_tag};
  assign {ImmExt, out_tag} = main_q;
`endif

  // Readiness comes from registered occupancy only, so downstream stalls never reach upstream combinationally.
  assign in_ready  = (state_q != TWO) && !reset;
  assign out_valid = (state_q != EMPTY);
  assign push_s    = in_valid && in_ready;
  assign pop_s     = out_valid && out_ready;

  // Occupancy next-state and main/skid steering.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (push_s) begin
          main_d  = in_item_s;
          state_d = ONE;
        end else begin
          state_d = EMPTY;
        end
      end
      ONE: begin
        if (push_s && pop_s) begin
          main_d  = in_item_s;
          state_d = ONE;
        end else if (push_s) begin
          skid_d  = in_item_s;
          state_d = TWO;
        end else if (pop_s) begin
          state_d = EMPTY;
        end else begin
          state_d = ONE;
        end
      end
      TWO: begin
        if (pop_s) begin
          main_d  = skid_q;
          state_d = ONE;
        end else begin
          state_d = TWO;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  // State and storage registers; reset drops any buffered items.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= {PW{1'b0}};
      skid_q  <= {PW{1'b0}};
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Scoreboard bench for imm_extend_pipe: XLEN=32 and XLEN=64 instances share one stimulus stream.
module tb_imm_extend_pipe;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [24:0]      instr = 25'd0;
  logic [2:0]       ImmSrc = 3'd0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             rdy32, rdy64, ov32, ov64;
  logic [31:0]      imm32;
  logic [63:0]      imm64;
  logic [TAG_W-1:0] tag32, tag64;
`ifdef IMM_ERR_EN
  logic             err32, err64;
`endif

  always #5 clk = ~clk;

  imm_extend_pipe #(.XLEN(32), .TAG_W(TAG_W)) dut32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy32),
    .instr(instr), .ImmSrc(ImmSrc), .in_tag(in_tag),
    .out_valid(ov32), .out_ready(out_ready), .ImmExt(imm32), .out_tag(tag32)
`ifdef IMM_ERR_EN
    , .imm_err(err32)
`endif
  );

  imm_extend_pipe #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy64),
    .instr(instr), .ImmSrc(ImmSrc), .in_tag(in_tag),
    .out_valid(ov64), .out_ready(out_ready), .ImmExt(imm64), .out_tag(tag64)
`ifdef IMM_ERR_EN
    , .imm_err(err64)
`endif
  );

  typedef struct {
    logic [63:0]      e32;
    logic [63:0]      e64;
    logic [TAG_W-1:0] tag;
    logic             err;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   done = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [24:0] ins_of(logic [31:0] word);
    return word[31:7];
  endfunction

  // Reference: rebuild the instruction word and assemble fields arithmetically.
  function automatic logic [63:0] ref_imm(logic [24:0] ins, logic [2:0] src, int xlen);
    logic [31:0] u, fill, r;
    logic        sx;
    logic [63:0] v;
    u    = {ins, 7'd0};
    fill = u[31] ? 32'hFFFF_FFFF : 32'd0;
    sx   = 1'b1;
    case (src)
      3'd0: r = (fill << 12) | ((u >> 20) & 32'hFFF);
      3'd1: r = (fill << 12) | (((u >> 25) & 32'h7F) << 5) | ((u >> 7) & 32'h1F);
      3'd2: r = (fill << 12) | (((u >> 7) & 32'd1) << 11) | (((u >> 25) & 32'h3F) << 5)
                | (((u >> 8) & 32'hF) << 1);
      3'd3: r = (fill << 20) | (((u >> 12) & 32'hFF) << 12) | (((u >> 20) & 32'd1) << 11)
                | (((u >> 21) & 32'h3FF) << 1);
      3'd5: begin r = (u >> 15) & 32'h1F; sx = 1'b0; end
      3'd6: begin r = (u >> 20) & ((xlen == 64) ? 32'h3F : 32'h1F); sx = 1'b0; end
      default: r = u & 32'hFFFF_F000;
    endcase
    v = (sx && r[31]) ? {32'hFFFF_FFFF, r} : {32'd0, r};
    if (xlen == 32) v = v & 64'h0000_0000_FFFF_FFFF;
    return v;
  endfunction

  // Input monitor: record every accepted item; reset discards everything in flight.
  initial forever begin
    @(negedge clk);
    #1;
    if (reset) q.delete();
    else if (in_valid && rdy32) q.push_back(cur);
  end

  // Output monitor: occupancy, stall stability and in-order data.
  initial begin
    logic             hold_v;
    logic [31:0]      hold_imm;
    logic [TAG_W-1:0] hold_tag;
    exp_t             e;
    hold_v = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        hold_v = 1'b0;
      end else begin
        check("in_ready32", rdy32, q.size() < 2);
        check("in_ready64", rdy64, q.size() < 2);
        check("out_valid32", ov32, q.size() != 0);
        check("out_valid64", ov64, q.size() != 0);
        if (hold_v && ov32) begin
          check("stall_imm", imm32, hold_imm);
          check("stall_tag", tag32, hold_tag);
        end
        hold_v   = ov32 && !out_ready;
        hold_imm = imm32;
        hold_tag = tag32;
        if (ov32 && out_ready) begin
          if (q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL pop_empty: output tag %0d appeared, expected no output", tag32);
          end else begin
            e = q.pop_front();
            check("imm32", imm32, e.e32);
            check("imm64", imm64, e.e64);
            check("tag32", tag32, e.tag);
            check("tag64", tag64, e.tag);
`ifdef IMM_ERR_EN
            check("err32", err32, e.err);
            check("err64", err64, e.err);
`endif
          end
        end
      end
    end
  end

  task automatic send(logic [24:0] ins, logic [2:0] src, logic [TAG_W-1:0] tag,
                      logic [63:0] e32, logic [63:0] e64);
    int budget;
    budget   = 50;
    instr    = ins;
    ImmSrc   = src;
    in_tag   = tag;
    cur.e32  = e32;
    cur.e64  = e64;
    cur.tag  = tag;
    cur.err  = (src == 3'b111);
    in_valid = 1'b1;
    @(negedge clk);
    while (!rdy32 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stayed 0, expected 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_rand(logic [TAG_W-1:0] tag);
    logic [24:0] ins;
    logic [2:0]  src;
    ins = 25'($urandom);
    src = 3'($urandom_range(7, 0));
    send(ins, src, tag, ref_imm(ins, src, 32), ref_imm(ins, src, 64));
  endtask

  task automatic drain();
    int budget;
    budget = 40;
    out_ready = 1'b1;
    while ((q.size() != 0 || ov32) && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    if (budget == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: %0d items still pending, expected 0", q.size());
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_imm32", imm32, 64'd0);
    check("rst_imm64", imm64, 64'd0);
    check("rst_tag32", tag32, 64'd0);
    @(posedge clk);
    #1;

    out_ready = 1'b1;
    send(ins_of(32'hFFF0_0093), 3'b000, 5'd1, 64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    send(ins_of(32'hFE20_AE23), 3'b001, 5'd2, 64'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC);
    send(ins_of(32'hFE00_0CE3), 3'b010, 5'd3, 64'hFFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFF8);
    send(ins_of(32'h0010_006F), 3'b011, 5'd4, 64'h0000_0800, 64'h0000_0800);
    send(ins_of(32'h000F_8073), 3'b101, 5'd5, 64'h0000_001F, 64'h0000_001F);
    send(ins_of(32'h8000_02B7), 3'b100, 5'd6, 64'h8000_0000, 64'hFFFF_FFFF_8000_0000);
    send(ins_of(32'h03F0_0013), 3'b110, 5'd7, 64'h0000_001F, 64'h0000_003F);
    send(ins_of(32'h1234_52B7), 3'b111, 5'd8, 64'h1234_5000, 64'h1234_5000);
    send(ins_of(32'h0010_0093), 3'b000, 5'd9, 64'h0000_0001, 64'h0000_0001);
    drain();

    // Backpressure: third item must wait until the stall is released.
    out_ready = 1'b0;
    fork
      begin
        send_rand(5'd1);
        send_rand(5'd2);
        send_rand(5'd3);
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset while full: both buffered items must vanish.
    out_ready = 1'b0;
    send_rand(5'd10);
    send_rand(5'd11);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst2_imm32", imm32, 64'd0);
    check("rst2_imm64", imm64, 64'd0);
    check("rst2_tag32", tag32, 64'd0);
    check("rst2_tag64", tag64, 64'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send_rand(5'd12);
    drain();

    fork
      begin
        for (int i = 0; i < 400; i++) begin
          if ($urandom_range(3, 0) == 0) begin
            @(posedge clk);
            #1;
          end
          send_rand(TAG_W'(i));
        end
        done = 1;
      end
      begin
        while (done == 0) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(3, 0) != 0);
        end
      end
    join
    drain();
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
Parametrised, registered immediate generator for the decode stage of the pipelined core. It accepts the instruction's upper bits, an immediate-format select and a sideband tag over a valid/ready handshake. It produces the sign- or zero-extended immediate at XLEN width after one register stage. A two-entry skid buffer sustains one result per cycle under downstream backpressure. Beyond the single-cycle generator, it adds CSR zimm and shift-amount formats, RV64 width and flow control.

Parameters:
XLEN, 32, output datapath width; legal values 32 or 64.
TAG_W, 5, width of the sideband tag carried with each item (e.g. rd index or ROB slot).

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  upstream item present
in_ready  output  1  block can accept an item this cycle
instr  input  25  instruction bits [31:7]; instr[k] carries instruction bit k
ImmSrc  input  3  immediate format select
in_tag  input  TAG_W  sideband tag, passed through unchanged
out_valid  output  1  result present
out_ready  input  1  downstream accepts the result
ImmExt  output  XLEN  extended immediate
out_tag  output  TAG_W  tag matching ImmExt

Behaviour:
- Reset: synchronous, active-high, on clk. Clears both entries. Next cycle: out_valid=0, ImmExt=0, out_tag=0. in_ready=0 while reset is high.
- Format decode (combinational, before the register). Sign bit is instr[31] unless stated:
  - 000 I: sext(instr[31:20]).
  - 001 S: sext({instr[31:25],instr[11:7]}).
  - 010 B: sext({instr[31],instr[7],instr[30:25],instr[11:8],0}).
  - 011 J: sext({instr[31],instr[19:12],instr[20],instr[30:21],0}).
  - 100 U: sext({instr[31:12],12'b0}). Identical to the 32-bit value when XLEN=32; sign-extended from bit 31 when XLEN=64.
  - 101 Z (CSR zimm): zext(instr[19:15]).
  - 110 SH (shamt): zext(instr[24:20]) when XLEN=32; zext(instr[25:20]) when XLEN=64.
  - 111 reserved: decodes as U (see Optional Feature).
- Handshake:
  - Transfer in on in_valid&&in_ready; transfer out on out_valid&&out_ready.
  - Latency is exactly 1 cycle from accept to out_valid when the block is empty.
  - Throughput is 1 item/cycle while out_ready stays high.
- Storage: main register (drives outputs) plus skid register. State = occupancy: EMPTY, ONE, TWO.
  - in_ready = (state != TWO) && !reset; depends on registered state only, never on out_ready.
  - EMPTY: accept -> ONE.
  - ONE: accept with no pop -> TWO (item goes to skid); pop with no accept -> EMPTY.
  - ONE, accept and pop in the same cycle: stays ONE; the new item loads the main register directly.
  - TWO: pop -> ONE, skid moves to main. No accept is possible in TWO.
- Ordering is strictly FIFO. ImmExt and out_tag must hold stable while out_valid && !out_ready.
- in_valid deasserting without a handshake has no effect. Inputs are ignored when in_ready=0.
- Reset mid-operation: all buffered items are discarded, not delivered. On the cycle after reset deasserts, in_ready=1 and out_valid=0.
- No combinational path from any input to out_valid, ImmExt or out_tag.

Optional Feature:
IMM_ERR_EN. When defined:
- Adds output port imm_err (1 bit), registered and buffered alongside ImmExt.
- imm_err=1 exactly when the item was accepted with ImmSrc=3'b111. ImmExt still carries the U decode.
- Reset value of imm_err is 0.
When not defined: the port is absent and 3'b111 silently decodes as U.

Test Plan:
- XLEN=32, I-type: instr=0xFFF00093>>7, ImmSrc=000, tag=1, out_ready=1 -> next cycle out_valid=1, ImmExt=0xFFFFFFFF, out_tag=1.
- Formats back-to-back, one per cycle, out_ready=1 -> results on consecutive cycles, no bubbles:
  - S 0xFE20AE23 -> 0xFFFFFFFC.
  - B 0xFE000CE3 -> 0xFFFFFFF8.
  - J 0x0010006F -> 0x00000800.
  - Z with instr[19:15]=5'h1F -> 0x0000001F.
- XLEN=64: U 0x800002B7 -> 0xFFFFFFFF80000000; SH with instr[25:20]=6'h3F -> 0x3F.
- Backpressure: out_ready=0, offer tags 1,2,3 on consecutive cycles:
  - Tags 1 and 2 are accepted; in_ready=0 after the second accept; tag 3 is held upstream.
  - Raise out_ready -> outputs appear in order 1,2,3 with ImmExt stable while stalled.
- Reset in TWO state: assert reset for 1 cycle -> next cycle out_valid=0, ImmExt=0, out_tag=0; buffered items are never delivered; in_ready=1 after reset deasserts.
- IMM_ERR_EN defined: ImmSrc=111, instr=0x123452B7>>7 -> ImmExt=0x12345000, imm_err=1; next item with ImmSrc=000 -> imm_err=0.
